alu_mc: RTL and testbench

- Parametrised, multi-cycle successor to the single-cycle EX-stage ALU of the pipelined CPU.
- Keeps the existing 4-bit operation encoding and adds a registered valid/ready handshake.
- Adds an iterative unsigned shift-add multiplier that returns the full 2×WIDTH product, replacing the combinational multiply.
- Sits in the EX stage; the hazard unit stalls the pipeline while ready_o is low.

---
 rtl/alu_mc_if.sv | 42 ++++
 rtl/alu_mc.sv | 214 +++++++++++++++++++++
 tb/tb_alu_mc.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_mc_if.sv
// -----------------------------------------------------------------------------
// alu_mc_if
// Request/response bundle between the EX stage and the multi-cycle ALU.
//
// Signals (names kept identical to the ALU port list):
//   valid_i   operation request from the pipeline
//   ready_o   ALU can accept an operation this cycle
//   flush_i   abort the in-flight operation (pipeline flush)
//   ctrl_i    4-bit operation code
//   src1_i    operand 1
//   src2_i    operand 2
//   result_o  registered result (low half of product for MUL)
//   hi_o      registered high half of product (remainder for DIVU)
//   zero_o    result_o == 0
//   valid_o   one-cycle pulse: result_o/hi_o updated this cycle
//
// Modports: master = pipeline side, slave = ALU side.
// -----------------------------------------------------------------------------
interface alu_mc_if #(
    parameter int WIDTH = 32
);
    logic             valid_i;
    logic             ready_o;
    logic             flush_i;
    logic [3:0]       ctrl_i;
    logic [WIDTH-1:0] src1_i;
    logic [WIDTH-1:0] src2_i;
    logic [WIDTH-1:0] result_o;
    logic [WIDTH-1:0] hi_o;
    logic             zero_o;
    logic             valid_o;

    modport master (
        output valid_i, flush_i, ctrl_i, src1_i, src2_i,
        input  ready_o, result_o, hi_o, zero_o, valid_o
    );

    modport slave (
        input  valid_i, flush_i, ctrl_i, src1_i, src2_i,
        output ready_o, result_o, hi_o, zero_o, valid_o
    );
endinterface

// File: rtl/alu_mc.sv
// -----------------------------------------------------------------------------
// alu_mc
// Multi-cycle EX-stage ALU. Single-cycle logic ops complete one cycle after
// acceptance; MUL (and DIVU when enabled) iterate WIDTH times in BUSY and
// report in cycle WIDTH+1. The hazard unit stalls while ready_o is low.
//
// Ports:
//   clk_i   clock, rising edge
//   rst_i   asynchronous, active-low reset
//   bus     alu_mc_if.slave (valid/ready/flush, ctrl, operands, results)
//
// Build option:
//   ALU_DIV_EN  when defined, code 1110 is DIVU (unsigned restoring divide,
//               quotient on result_o, remainder on hi_o). When undefined the
//               code is treated as undefined and no divider logic exists.
// -----------------------------------------------------------------------------
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic     clk_i,
    input  logic     rst_i,
    alu_mc_if.slave  bus
);
    localparam int SH_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] WIDTH_LIM = WIDTH'(WIDTH);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_SLT  = 4'b0100;
    localparam logic [3:0] OP_SRLV = 4'b0110;
    localparam logic [3:0] OP_LUI  = 4'b1000;
    localparam logic [3:0] OP_MUL  = 4'b1011;
`ifdef ALU_DIV_EN
    localparam logic [3:0] OP_DIVU = 4'b1110;
`endif

    typedef enum logic {IDLE, BUSY} state_t;

    state_t state, next_state;

    logic                 ready;
    logic                 accept;
    logic                 start_iter;
    logic                 last_iter;
    logic                 is_mc;

    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   acc;
    logic [CNT_W-1:0]     cnt;
    logic [WIDTH-1:0]     result_q;
    logic [WIDTH-1:0]     hi_q;
    logic                 valid_q;
    logic [2*WIDTH-1:0]   mul_acc_nxt;

    // Results of all ops that finish in one cycle. Branch codes and
    // undefined codes fall through to zero.
    function automatic logic [WIDTH-1:0] alu_single(
        input logic [3:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] r;
        r = '0;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_SLT:  r = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SRLV: r = (b >= WIDTH_LIM) ? '0 : (a >> b[SH_W-1:0]);
            OP_LUI:  r = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            default: r = '0;
        endcase
        return r;
    endfunction

    always_comb begin
        is_mc = (bus.ctrl_i == OP_MUL);
`ifdef ALU_DIV_EN
        if (bus.ctrl_i == OP_DIVU) begin
            is_mc = 1'b1;
        end
`endif
    end

    // ---- FSM: state register ----
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ---- FSM: next state and handshake; flush beats valid ----
    always_comb begin
        next_state = state;
        ready      = 1'b0;
        accept     = 1'b0;
        start_iter = 1'b0;
        last_iter  = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (bus.valid_i && !bus.flush_i) begin
                    accept = 1'b1;
                    if (is_mc) begin
                        start_iter = 1'b1;
                        next_state = BUSY;
                    end
                end
            end
            BUSY: begin
                if (bus.flush_i) begin
                    next_state = IDLE;
                end else if (cnt == CNT_W'(1)) begin
                    last_iter  = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // One shift-add step: add the multiplicand at its current weight.
    always_comb begin
        mul_acc_nxt = acc + (mplier[0] ? mcand : '0);
    end

`ifdef ALU_DIV_EN
    // Restoring divide step. The remainder lives in acc[WIDTH:0], the
    // dividend shifts out of mplier's MSB while quotient bits shift in at
    // its LSB, and the divisor sits in mcand[WIDTH-1:0]. A zero divisor
    // naturally yields an all-ones quotient and remainder = dividend.
    logic             op_div;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_nxt;
    logic             q_bit;
    logic [WIDTH-1:0] quo_nxt;

    always_comb begin
        rem_sh  = {acc[WIDTH-1:0], mplier[WIDTH-1]};
        q_bit   = (rem_sh >= {1'b0, mcand[WIDTH-1:0]});
        rem_nxt = q_bit ? (rem_sh - {1'b0, mcand[WIDTH-1:0]}) : rem_sh;
        quo_nxt = {mplier[WIDTH-2:0], q_bit};
    end
`endif

    // ---- Datapath and output registers ----
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            cnt      <= '0;
            result_q <= '0;
            hi_q     <= '0;
            valid_q  <= 1'b0;
`ifdef ALU_DIV_EN
            op_div   <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            if (accept && !is_mc) begin
                result_q <= alu_single(bus.ctrl_i, bus.src1_i, bus.src2_i);
                hi_q     <= '0;
                valid_q  <= 1'b1;
            end
            if (start_iter) begin
                mcand  <= {{WIDTH{1'b0}}, bus.src2_i};
                mplier <= bus.src1_i;
                acc    <= '0;
                cnt    <= CNT_W'(WIDTH);
`ifdef ALU_DIV_EN
                op_div <= (bus.ctrl_i == OP_DIVU);
`endif
            end else if (state == BUSY && !bus.flush_i) begin
                cnt <= cnt - CNT_W'(1);
`ifdef ALU_DIV_EN
                if (op_div) begin
                    acc    <= {{(WIDTH-1){1'b0}}, rem_nxt};
                    mplier <= quo_nxt;
                    if (last_iter) begin
                        result_q <= quo_nxt;
                        hi_q     <= rem_nxt[WIDTH-1:0];
                        valid_q  <= 1'b1;
                    end
                end else
`endif
                begin
                    acc    <= mul_acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    if (last_iter) begin
                        result_q <= mul_acc_nxt[WIDTH-1:0];
                        hi_q     <= mul_acc_nxt[2*WIDTH-1:WIDTH];
                        valid_q  <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.ready_o  = ready;
    assign bus.result_o = result_q;
    assign bus.hi_o     = hi_q;
    assign bus.valid_o  = valid_q;
    assign bus.zero_o   = (result_q == '0);

endmodule

// File: tb/tb_alu_mc.sv
module tb_alu_mc;
    localparam int W = 32;

    logic clk_i;
    logic rst_i;

    alu_mc_if #(.WIDTH(W)) bus ();

    alu_mc #(.WIDTH(W)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string        name;
        logic [3:0]   ctrl;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.valid_i = v;
        bus.ctrl_i  = c;
        bus.src1_i  = a;
        bus.src2_i  = b;
    endtask

    // Multi-cycle op from IDLE: checks stall window, prior-result hold, and
    // the single valid_o pulse in cycle W+1.
    task automatic mc_op(input string name, input logic [3:0] c, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] prev_lo,
                         input logic [W-1:0] exp_lo, input logic [W-1:0] exp_hi);
        int bad_busy;
        bad_busy = 0;
        drive(1'b1, c, a, b);
        step();
        drive(1'b0, 4'b0000, '0, '0);
        for (int k = 1; k <= W; k++) begin
            if (bus.ready_o !== 1'b0 || bus.valid_o !== 1'b0 || bus.result_o !== prev_lo) bad_busy++;
            step();
        end
        check({name, "_busy_window"}, 64'(bad_busy), 64'd0);
        check({name, "_valid"}, 64'(bus.valid_o), 64'd1);
        check({name, "_ready"}, 64'(bus.ready_o), 64'd1);
        check({name, "_lo"}, 64'(bus.result_o), 64'(exp_lo));
        check({name, "_hi"}, 64'(bus.hi_o), 64'(exp_hi));
        step();
        check({name, "_valid_drop"}, 64'(bus.valid_o), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        vecs.push_back('{"add_ovf",  4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000});
        vecs.push_back('{"and",      4'b0000, 32'hF0F0FF00, 32'h0FF0F0F0, 32'h00F0F000});
        vecs.push_back('{"or",       4'b0001, 32'hF0F00000, 32'h00000F0F, 32'hF0F00F0F});
        vecs.push_back('{"add_wrap", 4'b0010, 32'hFFFFFFFF, 32'h00000002, 32'h00000001});
        vecs.push_back('{"sub_wrap", 4'b0011, 32'h00000000, 32'h00000001, 32'hFFFFFFFF});
        vecs.push_back('{"slt_f",    4'b0100, 32'h00000005, 32'h00000003, 32'h00000000});
        vecs.push_back('{"slt_t",    4'b0100, 32'h00000003, 32'hFFFFFFFF, 32'h00000001});
        vecs.push_back('{"srlv4",    4'b0110, 32'h80000000, 32'h00000004, 32'h08000000});
        vecs.push_back('{"srlv31",   4'b0110, 32'h80000000, 32'h0000001F, 32'h00000001});
        vecs.push_back('{"srlv32",   4'b0110, 32'h80000000, 32'h00000020, 32'h00000000});
        vecs.push_back('{"lui",      4'b1000, 32'h00000000, 32'hABCD5678, 32'h56780000});
        vecs.push_back('{"branch7",  4'b0111, 32'h12345678, 32'h12345678, 32'h00000000});
        vecs.push_back('{"undef5",   4'b0101, 32'hFFFFFFFF, 32'h00000001, 32'h00000000});
        vecs.push_back('{"undef15",  4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000});
`ifndef ALU_DIV_EN
        vecs.push_back('{"code14",   4'b1110, 32'h00000064, 32'h00000007, 32'h00000000});
`endif

        rst_i = 1'b0;
        bus.flush_i = 1'b0;
        drive(1'b0, 4'b0000, '0, '0);
        step();
        step();
        check("rst_ready", 64'(bus.ready_o), 64'd1);
        check("rst_result", 64'(bus.result_o), 64'd0);
        check("rst_hi", 64'(bus.hi_o), 64'd0);
        check("rst_zero", 64'(bus.zero_o), 64'd1);
        check("rst_valid", 64'(bus.valid_o), 64'd0);
        rst_i = 1'b1;
        step();

        // Single-cycle table: one op per request, result in the next cycle.
        foreach (vecs[i]) begin
            check({vecs[i].name, "_ready"}, 64'(bus.ready_o), 64'd1);
            drive(1'b1, vecs[i].ctrl, vecs[i].a, vecs[i].b);
            step();
            drive(1'b0, 4'b0000, '0, '0);
            check({vecs[i].name, "_valid"}, 64'(bus.valid_o), 64'd1);
            check({vecs[i].name, "_res"}, 64'(bus.result_o), 64'(vecs[i].res));
            check({vecs[i].name, "_hi"}, 64'(bus.hi_o), 64'd0);
            check({vecs[i].name, "_zero"}, 64'(bus.zero_o), 64'(vecs[i].res == '0));
        end

        // Back-to-back SUB, SLT, SRLV.
        drive(1'b1, 4'b0011, 32'd5, 32'd5);
        step();
        check("b2b_sub_v", 64'(bus.valid_o), 64'd1);
        check("b2b_sub_r", 64'(bus.result_o), 64'd0);
        check("b2b_sub_z", 64'(bus.zero_o), 64'd1);
        drive(1'b1, 4'b0100, 32'd3, 32'hFFFFFFFF);
        step();
        check("b2b_slt_v", 64'(bus.valid_o), 64'd1);
        check("b2b_slt_r", 64'(bus.result_o), 64'd1);
        check("b2b_slt_z", 64'(bus.zero_o), 64'd0);
        drive(1'b1, 4'b0110, 32'h80000000, 32'd35);
        step();
        drive(1'b0, 4'b0000, '0, '0);
        check("b2b_srlv_v", 64'(bus.valid_o), 64'd1);
        check("b2b_srlv_r", 64'(bus.result_o), 64'd0);
        step();
        check("b2b_idle_v", 64'(bus.valid_o), 64'd0);

        // Flush in IDLE suppresses acceptance; previous result stays 0.
        bus.flush_i = 1'b1;
        drive(1'b1, 4'b0010, 32'd1, 32'd1);
        step();
        bus.flush_i = 1'b0;
        drive(1'b0, 4'b0000, '0, '0);
        check("idle_flush_v", 64'(bus.valid_o), 64'd0);
        check("idle_flush_r", 64'(bus.result_o), 64'd0);

        // Full-range multiply.
        mc_op("mul_max", 4'b1011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'h00000001, 32'hFFFFFFFE);

        // MUL with valid_i held during BUSY, flush in cycle 10.
        drive(1'b1, 4'b1011, 32'd1234, 32'd5678);
        step();
        for (int k = 1; k < 10; k++) begin
            check("flush_busy_ready", 64'(bus.ready_o), 64'd0);
            step();
        end
        bus.flush_i = 1'b1;
        step();
        bus.flush_i = 1'b0;
        drive(1'b0, 4'b0000, '0, '0);
        check("flush_ready", 64'(bus.ready_o), 64'd1);
        check("flush_valid", 64'(bus.valid_o), 64'd0);
        check("flush_lo", 64'(bus.result_o), 64'h00000001);
        check("flush_hi", 64'(bus.hi_o), 64'hFFFFFFFE);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.valid_o === 1'b1) n++;
            step();
        end
        check("flush_no_pulse", 64'(n), 64'd0);

        // MUL then back-to-back MUL accepted in the valid_o cycle.
        drive(1'b1, 4'b1011, 32'd3, 32'd5);
        step();
        drive(1'b0, 4'b0000, '0, '0);
        n = 1;
        while (bus.valid_o !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        check("mul35_latency", 64'(n), 64'd33);
        check("mul35_lo", 64'(bus.result_o), 64'd15);
        check("mul35_hi", 64'(bus.hi_o), 64'd0);
        check("mul35_ready", 64'(bus.ready_o), 64'd1);
        mc_op("mul_b2b", 4'b1011, 32'd7, 32'd6, 32'd15, 32'd42, 32'd0);

        // Reset in the middle of a MUL.
        drive(1'b1, 4'b1011, 32'd1234, 32'd5678);
        step();
        drive(1'b0, 4'b0000, '0, '0);
        for (int k = 1; k < 5; k++) step();
        rst_i = 1'b0;
        #1;
        check("midrst_ready", 64'(bus.ready_o), 64'd1);
        check("midrst_lo", 64'(bus.result_o), 64'd0);
        check("midrst_hi", 64'(bus.hi_o), 64'd0);
        check("midrst_zero", 64'(bus.zero_o), 64'd1);
        check("midrst_valid", 64'(bus.valid_o), 64'd0);
        step();
        rst_i = 1'b1;
        step();
        drive(1'b1, 4'b1000, 32'd0, 32'h00001234);
        step();
        drive(1'b0, 4'b0000, '0, '0);
        check("lui_after_rst_v", 64'(bus.valid_o), 64'd1);
        check("lui_after_rst_r", 64'(bus.result_o), 64'h12340000);

`ifdef ALU_DIV_EN
        mc_op("divu_100_7", 4'b1110, 32'd100, 32'd7, 32'h12340000, 32'd14, 32'd2);
        mc_op("divu_by0", 4'b1110, 32'd9, 32'd0, 32'd14, 32'hFFFFFFFF, 32'd9);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
